// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg
//   Shared definitions for the AHB-Lite GPIO: register byte offsets, the
//   register index enum and the offset decoder used by the top level.
package ahb_gpio_pkg;

  localparam logic [7:0] OFS_DATA    = 8'h00;
  localparam logic [7:0] OFS_DIR     = 8'h04;
  localparam logic [7:0] OFS_OUTSET  = 8'h08;
  localparam logic [7:0] OFS_OUTCLR  = 8'h0C;
  localparam logic [7:0] OFS_OUTTGL  = 8'h10;
  localparam logic [7:0] OFS_RISEEN  = 8'h14;
  localparam logic [7:0] OFS_FALLEN  = 8'h18;
  localparam logic [7:0] OFS_INTSTAT = 8'h1C;
  localparam logic [7:0] OFS_RAWIN   = 8'h20;

  typedef enum logic [3:0] {
    REG_DATA,
    REG_DIR,
    REG_OUTSET,
    REG_OUTCLR,
    REG_OUTTGL,
    REG_RISEEN,
    REG_FALLEN,
    REG_INTSTAT,
    REG_RAWIN,
    REG_NONE
  } reg_idx_e;

  // Exact match on the full byte offset; anything else is unmapped.
  function automatic reg_idx_e decode_ofs(input logic [7:0] ofs);
    reg_idx_e idx;
    case (ofs)
      OFS_DATA:    idx = REG_DATA;
      OFS_DIR:     idx = REG_DIR;
      OFS_OUTSET:  idx = REG_OUTSET;
      OFS_OUTCLR:  idx = REG_OUTCLR;
      OFS_OUTTGL:  idx = REG_OUTTGL;
      OFS_RISEEN:  idx = REG_RISEEN;
      OFS_FALLEN:  idx = REG_FALLEN;
      OFS_INTSTAT: idx = REG_INTSTAT;
      OFS_RAWIN:   idx = REG_RAWIN;
      default:     idx = REG_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ahb_gpio_ext_edge.sv
// gpio_edge_detect
//   Synchronises asynchronous GPIO pins through SYNC_STAGES flops, keeps a
//   one-cycle-delayed copy (prev) and produces per-bit rise/fall pulses.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset, clears chain and prev
//   pin   in   WIDTH asynchronous inputs
//   sync  out  WIDTH synchronised pin value
//   rise  out  WIDTH sync & ~prev
//   fall  out  WIDTH ~sync & prev
module gpio_edge_detect
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '{default: '0};
      prev  <= '0;
    end else begin
      chain[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      // prev follows the pin regardless of direction, so a bit turning
      // from output to input never sees a stale value and fakes an edge.
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ahb_gpio_ext.sv
// ahb_gpio_ext
//   AHB-Lite zero-wait-state GPIO slave: per-bit direction, atomic
//   set/clear/toggle of outputs, synchronised inputs, rise/fall edge
//   interrupts with W1C status and a single IRQ line.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HWDATA,
//   HREADY                AHB-Lite slave inputs (HADDR[7:0] decoded)
//   HREADYOUT, HRDATA     AHB-Lite slave outputs (HREADYOUT tied 1)
//   GPIOIN                asynchronous pin inputs
//   GPIOOUT, GPIOOE       output register, output enable (= DIR)
//   IRQ                   OR of all pending interrupt status bits
module ahb_gpio_ext
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [WIDTH-1:0] GPIOIN,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic [WIDTH-1:0] GPIOOUT,
  output logic [WIDTH-1:0] GPIOOE,
  output logic             IRQ
);

  logic             ap_sel, ap_trans, ap_write;
  logic [7:0]       ap_addr;
  reg_idx_e         ap_idx;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] out_r, dir_r, riseen_r, fallen_r, intstat_r;
  logic [WIDTH-1:0] sync_in, rise, fall, evt, w1c, rdata;

  logic unused;
  assign unused = &{1'b0, HADDR[31:8], HTRANS[0], HWDATA};

  // Address phase capture; only when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_sel   <= 1'b0;
      ap_trans <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= '0;
    end else if (HREADY) begin
      ap_sel   <= HSEL;
      ap_trans <= HTRANS[1];
      ap_write <= HWRITE;
      ap_addr  <= HADDR[7:0];
    end
  end

  assign ap_idx = decode_ofs(ap_addr);
  // Data phase ends only on HREADY; gating keeps a stalled phase from
  // committing a set/clear/toggle more than once.
  assign wr_en  = ap_sel & ap_trans & ap_write & HREADY;
  assign rd_en  = ap_sel & ap_trans & ~ap_write;
  assign wdata  = HWDATA[WIDTH-1:0];

  gpio_edge_detect #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk (HCLK),
    .rst (HRESET),
    .pin (GPIOIN),
    .sync(sync_in),
    .rise(rise),
    .fall(fall)
  );

  assign evt = ~dir_r & ((rise & riseen_r) | (fall & fallen_r));
  assign w1c = (wr_en && ap_idx == REG_INTSTAT) ? wdata : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      out_r     <= '0;
      dir_r     <= '0;
      riseen_r  <= '0;
      fallen_r  <= '0;
      intstat_r <= '0;
    end else begin
      // A new event wins over a simultaneous clear.
      intstat_r <= evt | (intstat_r & ~w1c);
      if (wr_en) begin
        case (ap_idx)
          REG_DATA:   out_r    <= wdata;
          REG_DIR:    dir_r    <= wdata;
          REG_OUTSET: out_r    <= out_r | wdata;
          REG_OUTCLR: out_r    <= out_r & ~wdata;
          REG_OUTTGL: out_r    <= out_r ^ wdata;
          REG_RISEEN: riseen_r <= wdata;
          REG_FALLEN: fallen_r <= wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (ap_idx)
        REG_DATA:    rdata = (dir_r & out_r) | (~dir_r & sync_in);
        REG_DIR:     rdata = dir_r;
        REG_RISEEN:  rdata = riseen_r;
        REG_FALLEN:  rdata = fallen_r;
        REG_INTSTAT: rdata = intstat_r;
        REG_RAWIN:   rdata = sync_in;
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    HRDATA             = '0;
    HRDATA[WIDTH-1:0]  = rdata;
  end

  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = out_r;
  assign GPIOOE    = dir_r;
  assign IRQ       = |intstat_r;

endmodule

// File: tb/tb_ahb_gpio_ext.sv
// tb_ahb_gpio_ext
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference model (register values plus a pin history queue).
module tb_ahb_gpio_ext;

  localparam int W = 16;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic [W-1:0]  GPIOIN;
  logic          HREADYOUT, IRQ;
  logic [31:0]   HRDATA;
  logic [W-1:0]  GPIOOUT, GPIOOE;

  always #5 HCLK = ~HCLK;

  ahb_gpio_ext #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(GPIOIN),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOOUT(GPIOOUT), .GPIOOE(GPIOOE),
    .IRQ(IRQ)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_out, m_dir, m_rise, m_fall, m_int;
  logic [15:0] hist [$];   // hist[0] = pin value seen at the most recent edge
  bit          pend_wr;
  logic [7:0]  pend_addr;
  logic [15:0] pend_data;

  logic [7:0] addrs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                             8'h18, 8'h1C, 8'h20, 8'h24, 8'h3C};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // The pin reaches the readable value two edges after it is applied.
  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [15:0] s;
    logic [31:0] r;
    s = hist[1];
    case (a)
      8'h00:   r = {16'h0, (m_dir & m_out) | (~m_dir & s)};
      8'h04:   r = {16'h0, m_dir};
      8'h14:   r = {16'h0, m_rise};
      8'h18:   r = {16'h0, m_fall};
      8'h1C:   r = {16'h0, m_int};
      8'h20:   r = {16'h0, s};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic tick();
    logic        rst;
    logic [15:0] s, p, evt, w1c;
    rst = HRESET;
    hist.push_front(GPIOIN);
    if (hist.size() > 8) void'(hist.pop_back());
    s = hist[2];   // synchronised level this edge sees
    p = hist[3];   // level one cycle earlier
    @(posedge HCLK);
    #1;
    if (rst) begin
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_int = '0;
      hist = '{16'h0, 16'h0, 16'h0, 16'h0};
    end else begin
      evt   = ~m_dir & ((s & ~p & m_rise) | (~s & p & m_fall));
      w1c   = (pend_wr && pend_addr == 8'h1C) ? pend_data : 16'h0;
      m_int = evt | (m_int & ~w1c);
      if (pend_wr) begin
        case (pend_addr)
          8'h00: m_out  = pend_data;
          8'h04: m_dir  = pend_data;
          8'h08: m_out  = m_out | pend_data;
          8'h0C: m_out  = m_out & ~pend_data;
          8'h10: m_out  = m_out ^ pend_data;
          8'h14: m_rise = pend_data;
          8'h18: m_fall = pend_data;
          default: ;
        endcase
      end
    end
    pend_wr = 1'b0;
    check("gpioout", {16'h0, GPIOOUT}, {16'h0, m_out});
    check("gpiooe", {16'h0, GPIOOE}, {16'h0, m_dir});
    check("irq", {31'h0, IRQ}, {31'h0, (m_int != 16'h0)});
    check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HREADY = 1'b1;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [15:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a}; HREADY = 1'b1;
    tick();
    idle_bus();
    HWDATA    = {16'hA5A5, d};
    pend_wr   = 1'b1;
    pend_addr = a;
    pend_data = d;
    tick();
  endtask

  task automatic ahb_read(input logic [7:0] a, input string tag, output logic [31:0] v);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a}; HREADY = 1'b1;
    tick();
    idle_bus();
    v = HRDATA;
    check(tag, HRDATA, model_read(a));
    tick();
  endtask

  initial begin
    logic [31:0] v;
    int          op;
    logic [7:0]  a;

    hist    = '{16'h0, 16'h0, 16'h0, 16'h0};
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_int = '0;
    pend_wr = 1'b0; pend_addr = '0; pend_data = '0;
    idle_bus();
    HWDATA = '0; GPIOIN = '0; HRESET = 1'b1;
    ticks(2);
    HRESET = 1'b0;
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_gpioout", {16'h0, GPIOOUT}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);

    // 1: reset lands in the data phase of a DATA write
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    tick();
    idle_bus();
    HWDATA = 32'h0000FFFF; HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    tick();
    check("t1_gpioout", {16'h0, GPIOOUT}, 32'h0);
    ahb_read(8'h00, "t1_data", v);

    // 2: direction plus atomic output ops, then mixed DATA readback
    ahb_write(8'h04, 16'h00FF);
    ahb_write(8'h00, 16'h1234);
    ahb_write(8'h08, 16'h0F00);
    ahb_write(8'h0C, 16'h0004);
    ahb_write(8'h10, 16'h0011);
    check("t2_gpioout", {16'h0, GPIOOUT}, 32'h00001F21);
    check("t2_gpiooe", {16'h0, GPIOOE}, 32'h000000FF);
    GPIOIN = 16'hABCD;
    ticks(3);
    ahb_read(8'h00, "t2_data", v);
    check("t2_data_const", v, 32'h0000AB21);

    // 3: rising edge interrupt latency and W1C
    GPIOIN = 16'h0000;
    ticks(3);
    ahb_write(8'h04, 16'h0000);
    ahb_write(8'h14, 16'h0001);
    ahb_write(8'h1C, 16'hFFFF);
    check("t3_irq_idle", {31'h0, IRQ}, 32'h0);
    GPIOIN = 16'h0001;
    tick();
    check("t3_irq_k", {31'h0, IRQ}, 32'h0);
    tick();
    check("t3_irq_k1", {31'h0, IRQ}, 32'h0);
    tick();
    check("t3_irq_k2", {31'h0, IRQ}, 32'h1);
    ahb_read(8'h1C, "t3_intstat", v);
    check("t3_intstat_const", v, 32'h00000001);
    ahb_write(8'h1C, 16'h0001);
    check("t3_irq_cleared", {31'h0, IRQ}, 32'h0);

    // 4: falling edge coincident with W1C keeps the bit set
    ahb_write(8'h18, 16'h8000);
    GPIOIN = 16'h8001;
    ticks(3);
    GPIOIN = 16'h0001;
    ticks(3);
    GPIOIN = 16'h8001;
    ticks(3);
    GPIOIN = 16'h0001;
    tick();
    ahb_write(8'h1C, 16'h8000);
    ahb_read(8'h1C, "t4_intstat", v);
    check("t4_bit15", v & 32'h8000, 32'h00008000);

    // 5: edges on output bits never raise status; RAWIN still follows
    ahb_write(8'h1C, 16'hFFFF);
    ahb_write(8'h04, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      GPIOIN[0] = ~GPIOIN[0];
      ticks(2);
      ahb_read(8'h20, "t5_rawin", v);
    end
    ahb_read(8'h1C, "t5_intstat", v);
    check("t5_intstat_const", v, 32'h0);
    ahb_write(8'h04, 16'h0000);
    ticks(3);
    ahb_read(8'h1C, "t5_dir_release", v);

    // 6: HREADY low in address phase, unmapped read, upper bits zero
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4; HREADY = 1'b0;
    tick();
    idle_bus();
    HWDATA = 32'h0000FFFF;
    tick();
    check("t6_gpiooe", {16'h0, GPIOOE}, 32'h0);
    ahb_read(8'h40, "t6_unmapped", v);
    check("t6_unmapped_const", v, 32'h0);
    GPIOIN = 16'hFFFF;
    ticks(3);
    ahb_read(8'h20, "t6_rawin", v);
    check("t6_upper", v >> 16, 32'h0);

    // Back-to-back: write DIR then read DIR in the overlapping cycle
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
    tick();
    HWRITE = 1'b0; HWDATA = 32'h00003C5A;
    pend_wr = 1'b1; pend_addr = 8'h04; pend_data = 16'h3C5A;
    tick();
    idle_bus();
    check("b2b_dir", HRDATA, model_read(8'h04));
    check("b2b_dir_const", HRDATA, 32'h00003C5A);
    tick();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 3));
      a  = addrs[$urandom_range(0, 10)];
      case (op)
        0: begin GPIOIN = 16'($urandom); tick(); end
        1: ahb_write(a, 16'($urandom));
        2: ahb_read(a, "rnd_read", v);
        default: tick();
      endcase
    end
    ahb_read(8'h1C, "final_intstat", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
